// File: rtl/ids_lab05_dec_sequencer.sv
// Purpose: drives select (A) and enable (E) of a 1-to-2 decoder, either one commanded pair or a 4-step sweep.
// Latency: START accepted at edge t gives valid A/E/BUSY from t+1; DONE pulses the cycle after the last busy cycle.
// Backpressure: none; START is ignored while busy, ABORT returns to idle on the next edge.
module ids_lab05_dec_sequencer #(
    parameter int DWELL = 4,
    parameter int GAP   = 1
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       START,
    input  logic       MODE,
    input  logic       SEL_IN,
    input  logic       EN_IN,
    input  logic       ABORT,
    output logic       A,
    output logic       E,
    output logic       BUSY,
    output logic       DONE,
    output logic [1:0] STEP
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    // Reload values for the 8-bit dwell/gap counter; the gap reload is unused when GAP is 0.
    localparam logic [7:0] DWELL_M1 = 8'(DWELL - 1);
    localparam logic [7:0] GAP_M1   = (GAP > 0) ? 8'(GAP - 1) : 8'd0;

    state_t     state, state_nxt;
    logic [7:0] cnt, cnt_nxt;
    logic       mode_q, mode_nxt;
    logic       a_nxt, e_nxt, busy_nxt, done_nxt;
    logic [1:0] step_nxt;
    logic [1:0] step_inc;

    // Next sweep step; its two bits are also the {A,E} pair for that step.
    assign step_inc = STEP + 2'd1;

    // State and output registers; every output comes straight from a flop.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state  <= S_IDLE;
            cnt    <= 8'd0;
            mode_q <= 1'b0;
            A      <= 1'b0;
            E      <= 1'b0;
            BUSY   <= 1'b0;
            DONE   <= 1'b0;
            STEP   <= 2'd0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            mode_q <= mode_nxt;
            A      <= a_nxt;
            E      <= e_nxt;
            BUSY   <= busy_nxt;
            DONE   <= done_nxt;
            STEP   <= step_nxt;
        end
    end

    // Next-state and next-output decode; ABORT overrides everything else.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        mode_nxt  = mode_q;
        a_nxt     = A;
        e_nxt     = E;
        busy_nxt  = BUSY;
        done_nxt  = 1'b0;
        step_nxt  = STEP;

        case (state)
            S_IDLE: begin
                a_nxt    = 1'b0;
                e_nxt    = 1'b0;
                busy_nxt = 1'b0;
                step_nxt = 2'd0;
                if (START) begin
                    state_nxt = S_DRIVE;
                    mode_nxt  = MODE;
                    cnt_nxt   = DWELL_M1;
                    busy_nxt  = 1'b1;
                    // Sweep always begins with the 00 pair.
                    a_nxt     = MODE ? 1'b0 : SEL_IN;
                    e_nxt     = MODE ? 1'b0 : EN_IN;
                end
            end
            S_DRIVE: begin
                if (cnt != 8'd0) begin
                    cnt_nxt = cnt - 8'd1;
                end else if (!mode_q || STEP == 2'd3) begin
                    state_nxt = S_IDLE;
                    a_nxt     = 1'b0;
                    e_nxt     = 1'b0;
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                    step_nxt  = 2'd0;
                end else if (GAP > 0) begin
                    state_nxt = S_GAP;
                    a_nxt     = 1'b0;
                    e_nxt     = 1'b0;
                    cnt_nxt   = GAP_M1;
                end else begin
                    step_nxt = step_inc;
                    a_nxt    = step_inc[1];
                    e_nxt    = step_inc[0];
                    cnt_nxt  = DWELL_M1;
                end
            end
            S_GAP: begin
                a_nxt = 1'b0;
                e_nxt = 1'b0;
                if (cnt != 8'd0) begin
                    cnt_nxt = cnt - 8'd1;
                end else begin
                    state_nxt = S_DRIVE;
                    step_nxt  = step_inc;
                    a_nxt     = step_inc[1];
                    e_nxt     = step_inc[0];
                    cnt_nxt   = DWELL_M1;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        if (ABORT) begin
            state_nxt = S_IDLE;
            cnt_nxt   = 8'd0;
            a_nxt     = 1'b0;
            e_nxt     = 1'b0;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b0;
            step_nxt  = 2'd0;
        end
    end

endmodule

// File: tb/tb_ids_lab05_dec_sequencer.sv
// Purpose: scoreboard bench for the decoder sequencer, default GAP=1 instance and a GAP=0 instance side by side.
// Latency: expected per-cycle outputs are queued when START is accepted and popped one per cycle.
// Backpressure: none; START acceptance is predicted from the expected queue being empty.
module tb_ids_lab05_dec_sequencer;

    localparam int DW = 4;

    typedef struct packed {
        logic       a;
        logic       e;
        logic       busy;
        logic       done;
        logic [1:0] step;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n, start, mode, sel_in, en_in, abort;
    logic a1, e1, busy1, done1;
    logic [1:0] step1;
    logic a0, e0, busy0, done0;
    logic [1:0] step0;

    int n_vec = 0;
    int n_err = 0;
    int cyc_n = 0;

    exp_t q1[$];
    exp_t q0[$];

    always #5 clk = ~clk;

    ids_lab05_dec_sequencer #(.DWELL(DW), .GAP(1)) dut_g1 (
        .CLK(clk), .RST_N(rst_n), .START(start), .MODE(mode), .SEL_IN(sel_in),
        .EN_IN(en_in), .ABORT(abort), .A(a1), .E(e1), .BUSY(busy1), .DONE(done1), .STEP(step1)
    );

    ids_lab05_dec_sequencer #(.DWELL(DW), .GAP(0)) dut_g0 (
        .CLK(clk), .RST_N(rst_n), .START(start), .MODE(mode), .SEL_IN(sel_in),
        .EN_IN(en_in), .ABORT(abort), .A(a0), .E(e0), .BUSY(busy0), .DONE(done0), .STEP(step0)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc_n, got, exp);
        end
    endtask

    function automatic exp_t mk(input logic a, input logic e, input logic b,
                                input logic d, input logic [1:0] s);
        exp_t x;
        x.a = a; x.e = e; x.busy = b; x.done = d; x.step = s;
        return x;
    endfunction

    // Expected cycle-by-cycle outputs of one whole operation, DONE cycle included.
    task automatic push_op(input int k, input int gap, input logic md,
                           input logic sl, input logic en);
        exp_t seq[$];
        if (!md) begin
            for (int i = 0; i < DW; i++) seq.push_back(mk(sl, en, 1'b1, 1'b0, 2'd0));
        end else begin
            for (int s = 0; s < 4; s++) begin
                logic [1:0] sv;
                sv = 2'(s);
                for (int i = 0; i < DW; i++) seq.push_back(mk(sv[1], sv[0], 1'b1, 1'b0, sv));
                if (s < 3)
                    for (int i = 0; i < gap; i++) seq.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, sv));
            end
        end
        seq.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 2'd0));
        foreach (seq[i]) begin
            if (k == 1) q1.push_back(seq[i]);
            else        q0.push_back(seq[i]);
        end
    endtask

    task automatic check_inst(input string tag, input exp_t ex, input logic a, input logic e,
                              input logic b, input logic d, input logic [1:0] s);
        logic [5:0] mask;
        // Leave STEP unchecked in the DONE cycle only.
        mask = ex.done ? 6'b111100 : 6'b111111;
        chk({tag, "_out"}, 32'({a, e, b, d, s} & mask), 32'(ex & mask));
        // Decoder outputs {D1,D0} = {E&A, E&~A}.
        chk({tag, "_dec"}, 32'({e & a, e & ~a}), 32'({ex.e & ex.a, ex.e & ~ex.a}));
    endtask

    // Apply inputs for the next edge, predict, then compare after that edge.
    task automatic cyc(input logic r, input logic st, input logic md, input logic sl,
                       input logic en, input logic ab);
        exp_t x1, x0;
        rst_n = r; start = st; mode = md; sel_in = sl; en_in = en; abort = ab;
        if (!r || ab) begin
            q1.delete();
            q0.delete();
        end else if (st) begin
            if (q1.size() == 0) push_op(1, 1, md, sl, en);
            if (q0.size() == 0) push_op(0, 0, md, sl, en);
        end
        @(negedge clk);
        cyc_n++;
        x1 = (q1.size() != 0) ? q1.pop_front() : mk(1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        x0 = (q0.size() != 0) ? q0.pop_front() : mk(1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        check_inst("g1", x1, a1, e1, busy1, done1, step1);
        check_inst("g0", x0, a0, e0, busy0, done0, step0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int busy_cnt;
        // Reset held two cycles with START high.
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        idle(3);

        // Single pairs.
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        idle(7);
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(6);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(6);

        // Sweep with START/MODE/SEL_IN noise while both instances are busy.
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        busy_cnt = 0;
        for (int i = 0; i < 14; i++) begin
            if (busy1) busy_cnt++;
            cyc(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
        end
        for (int i = 0; i < 10; i++) begin
            if (busy1) busy_cnt++;
            cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        chk("sweep_busy_len", 32'(busy_cnt), 32'(4 * DW + 3));
        idle(4);

        // START held high: each instance restarts in its DONE cycle.
        for (int i = 0; i < 45; i++) cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(24);

        // ABORT during step 2 of the GAP=1 sweep.
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(11);
        chk("pre_abort_step", 32'(step1), 32'd2);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(6);

        // START together with ABORT in idle.
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        idle(3);

        // Reset in the middle of a sweep.
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(5);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(4);

        chk("q1_drained", 32'(q1.size()), 32'd0);
        chk("q0_drained", 32'(q0.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
